// File: rtl/decrementer5b_timer.sv
// Loadable down-counting timer on a ripple-borrow decrement chain; one-shot or auto-reload.
// Latency: load/step visible one cycle after the edge; done is a registered 1-cycle pulse.
module decrementer5b_timer #(
  parameter int unsigned WIDTH       = 5,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] count_d;
  logic             zero_below;

  // Bit i toggles when every lower bit is zero, i.e. the borrow ripples up to it.
  always_comb begin
    count_d    = '0;
    zero_below = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      count_d[i] = count_q[i] ^ zero_below;
      zero_below = zero_below & ~count_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else if (load) begin
        count_q  <= load_val;
        reload_q <= load_val;
        if (load_val != '0) begin
          state_q <= ST_RUN;
          busy_q  <= 1'b1;
        end else begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_RUN: begin
            if (enable) begin
              // Expiry is caught at 1 so the chain never wraps through zero.
              if (count_q == WIDTH'(1)) begin
                done_q <= 1'b1;
                if (AUTO_RELOAD) begin
                  count_q <= reload_q;
                end else begin
                  count_q <= '0;
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                end
              end else begin
                count_q <= count_d;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_decrementer5b_timer.sv
// Drives one-shot and auto-reload timers with identical stimulus and checks both
// against a behavioural model of the timer rules.
module tb_decrementer5b_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [4:0] load_val = '0;
  logic       enable = 1'b0;
  logic       abort = 1'b0;

  logic [4:0] cnt_os, cnt_ar;
  logic       busy_os, busy_ar, done_os, done_ar;

  int total = 0;
  int bad   = 0;

  // Model state per instance: index 0 one-shot, 1 auto-reload.
  // m_mode: 0 idle, 1 counting, 2 expired-this-cycle.
  int m_mode [2];
  int m_cnt  [2];
  int m_rel  [2];
  int m_done [2];

  always #5 clk = ~clk;

  decrementer5b_timer #(.WIDTH(5), .AUTO_RELOAD(1'b0)) u_os (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .enable(enable),
    .abort(abort), .count(cnt_os), .busy(busy_os), .done(done_os)
  );

  decrementer5b_timer #(.WIDTH(5), .AUTO_RELOAD(1'b1)) u_ar (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .enable(enable),
    .abort(abort), .count(cnt_ar), .busy(busy_ar), .done(done_ar)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_cnt[k] = 0; m_rel[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0;
      if (rst) begin
        m_mode[k] = 0; m_cnt[k] = 0; m_rel[k] = 0;
      end else if (abort) begin
        m_mode[k] = 0;
      end else if (load) begin
        m_cnt[k] = int'(load_val);
        m_rel[k] = int'(load_val);
        if (load_val != 0) m_mode[k] = 1;
        else begin m_mode[k] = 2; m_done[k] = 1; end
      end else if (m_mode[k] == 1) begin
        if (enable) begin
          if (m_cnt[k] == 1) begin
            m_done[k] = 1;
            if (k == 1) m_cnt[k] = m_rel[k];
            else begin m_cnt[k] = 0; m_mode[k] = 2; end
          end else begin
            m_cnt[k] = m_cnt[k] - 1;
          end
        end
      end else if (m_mode[k] == 2) begin
        m_mode[k] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".os.count"}, int'(cnt_os),  m_cnt[0]);
    chk({tag, ".os.busy"},  int'(busy_os), (m_mode[0] == 1) ? 1 : 0);
    chk({tag, ".os.done"},  int'(done_os), m_done[0]);
    chk({tag, ".ar.count"}, int'(cnt_ar),  m_cnt[1]);
    chk({tag, ".ar.busy"},  int'(busy_ar), (m_mode[1] == 1) ? 1 : 0);
    chk({tag, ".ar.done"},  int'(done_ar), m_done[1]);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic ld, input int lv, input logic en, input logic ab);
    load = ld; load_val = 5'(lv); enable = en; abort = ab;
  endtask

  int dones;

  initial begin
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: asynchronous reset mid-run at count 17
    drive(1, 20, 1, 0); tick("t1.load");
    drive(0, 0, 1, 0);
    repeat (3) tick("t1.run");
    chk("t1.pre_rst_count", int'(cnt_os), 17);
    #2; rst = 1'b1; #1;
    model_reset();
    check_all("t1.async_rst");
    tick("t1.held");
    rst = 1'b0;

    // T2: one-shot load 5, enable held
    drive(1, 5, 1, 0); tick("t2.load");
    drive(0, 0, 1, 0);
    repeat (5) tick("t2.run");
    chk("t2.os_count_zero", int'(cnt_os), 0);
    chk("t2.os_done_at_zero", int'(done_os), 1);
    tick("t2.idle");
    chk("t2.os_done_cleared", int'(done_os), 0);
    drive(0, 0, 0, 0);
    tick("t2.quiet");

    // T3: enable pattern 1,0,1,0,1
    drive(1, 3, 0, 0); tick("t3.load");
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, (i % 2 == 0), 0);
      tick("t3.step");
    end
    chk("t3.os_done_after_3rd", int'(done_os), 1);
    drive(0, 0, 0, 0); tick("t3.idle");

    // T4: auto-reload period of 3 strobes
    drive(1, 3, 1, 0); tick("t4.load");
    drive(0, 0, 1, 0);
    dones = 0;
    for (int i = 0; i < 9; i++) begin
      tick("t4.run");
      if (done_ar) dones++;
    end
    chk("t4.ar_done_count", dones, 3);
    chk("t4.ar_busy_held", int'(busy_ar), 1);

    // T5: load 0 then load 31
    drive(1, 0, 1, 0); tick("t5.load0");
    chk("t5.load0_done", int'(done_os), 1);
    chk("t5.load0_busy", int'(busy_os), 0);
    drive(0, 0, 0, 0); tick("t5.after0");
    drive(1, 31, 1, 0); tick("t5.load31");
    drive(0, 0, 1, 0);
    for (int i = 0; i < 30; i++) tick("t5.run31");
    chk("t5.no_done_before_31", int'(done_os), 0);
    tick("t5.strobe31");
    chk("t5.done_on_31", int'(done_os), 1);
    drive(0, 0, 0, 0); tick("t5.idle");

    // T6: reload mid-run, then abort with simultaneous load
    drive(1, 9, 1, 0); tick("t6.load9");
    drive(0, 0, 1, 0);
    repeat (3) tick("t6.run9");
    chk("t6.at6", int'(cnt_os), 6);
    drive(1, 4, 1, 0); tick("t6.load4");
    drive(0, 0, 1, 0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick("t6.run4");
      if (done_os) dones++;
    end
    chk("t6.single_done", dones, 1);
    drive(1, 5, 1, 0); tick("t6.load5");
    drive(0, 0, 1, 0);
    repeat (3) tick("t6.run5");
    drive(1, 7, 1, 1); tick("t6.abort_load");
    chk("t6.abort_count", int'(cnt_os), 2);
    chk("t6.abort_busy", int'(busy_os), 0);
    drive(0, 0, 1, 0);
    repeat (2) tick("t6.idle");
    chk("t6.no_done", int'(done_os), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      drive($urandom_range(0, 15) == 0,
            (r < 10) ? 0 : (r < 20) ? 31 : $urandom_range(1, 12),
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 31) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2; rst = 1'b1; #1;
        model_reset();
        check_all("rand.async_rst");
        tick("rand.rst_held");
        rst = 1'b0;
      end else begin
        tick("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
